// File: rtl/ebu_burst_arb.sv
`default_nettype none
// ============================================================================
// Module  : ebu_burst_arb
// Brief   : N-requester AHB-Lite burst arbiter. Requester 0 has fixed priority
//           with a starvation guard; the others share round-robin.
// Revision: 1.0
// ============================================================================
module ebu_burst_arb #(
    parameter int NREQ   = 3,
    parameter int STARVE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     Req,
    input  logic [3*NREQ-1:0]   ReqBurst,
    input  logic [1:0]          HTRANS,
    input  logic                HREADY,
    input  logic                HRESP,
    output logic [NREQ-1:0]     Grant,
    output logic [2:0]          Owner,
    output logic                Busy,
    output logic                LastBeat
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            unb_q, unb_d;
    logic [2:0]      rr_q, rr_d;
    logic [3:0]      starve_q, starve_d;

    logic [NREQ-1:0] excl;
    logic [NREQ-1:0] elig;
    logic            others;
    logic            win_valid;
    logic [2:0]      win_idx;
    logic [2:0]      win_burst;
    logic [2:0]      owner_enc;
    logic            accept;
    logic            owner_req;
    logic            last;
    logic            do_arb;

    assign Grant     = grant_q;
    assign Owner     = owner_enc;
    assign Busy      = |grant_q;
    assign LastBeat  = last;
    assign accept    = Busy & HREADY & HTRANS[1];
    assign owner_req = |(Req & grant_q);

    always_comb begin
        owner_enc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) owner_enc = 3'(i);
        end
    end

    // The current owner is never eligible on its own last beat.
    always_comb begin
        excl      = (state_q == S_OWN) ? grant_q : '0;
        elig      = Req & ~excl;
        others    = |elig[NREQ-1:1];
        win_valid = 1'b0;
        win_idx   = '0;
        win_burst = '0;
        if (elig[0] && !((int'(starve_q) == STARVE) && others)) begin
            win_valid = 1'b1;
        end else begin
            for (int i = 1; i < NREQ; i++) begin
                if (!win_valid && elig[i] && (i >= int'(rr_q))) begin
                    win_valid = 1'b1;
                    win_idx   = 3'(i);
                end
            end
            for (int i = 1; i < NREQ; i++) begin
                if (!win_valid && elig[i]) begin
                    win_valid = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == win_idx) win_burst = ReqBurst[3*i +: 3];
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        unb_d    = unb_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        last     = 1'b0;

        if (state_q == S_OWN) begin
            if (HREADY && HRESP) begin
                last = 1'b1;
            end else if (unb_q) begin
                last = HREADY && ((HTRANS == 2'b00) || !owner_req);
            end else begin
                last = accept && (cnt_q == 5'd1);
            end
            if (accept && !unb_q && (cnt_q != 5'd0)) cnt_d = cnt_q - 5'd1;
        end

        do_arb = (state_q == S_IDLE) ? ((|Req) && HREADY) : last;

        if (do_arb) begin
            if (win_valid) begin
                state_d = S_OWN;
                for (int i = 0; i < NREQ; i++) begin
                    grant_d[i] = (3'(i) == win_idx);
                end
                unb_d = 1'b0;
                case (win_burst)
                    3'b000:          cnt_d = 5'd1;
                    3'b001: begin
                        cnt_d = 5'd0;
                        unb_d = 1'b1;
                    end
                    3'b010, 3'b011:  cnt_d = 5'd4;
                    3'b100, 3'b101:  cnt_d = 5'd8;
                    default:         cnt_d = 5'd16;
                endcase
                if (win_idx == 3'd0) begin
                    if (!others)                           starve_d = '0;
                    else if (int'(starve_q) < STARVE)      starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = '0;
                    rr_d     = (int'(win_idx) + 1 >= NREQ) ? 3'd1 : win_idx + 3'd1;
                end
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                cnt_d   = '0;
                unb_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            unb_q    <= 1'b0;
            rr_q     <= 3'd1;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            unb_q    <= unb_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

endmodule
`default_nettype wire
